// File: rtl/instr_encoder_if.sv
// Host-to-encoder instruction handshake and encoder-to-imem write port.
// The encoder is the slave of this bundle; the host/memory side is the master.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [3:0]        in_rd;
    logic [3:0]        in_rs;
    logic [3:0]        in_rt;
    logic [27:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instructions from a host into 32-bit words and writes them
// into instruction memory at consecutive addresses, one word per handshake.
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            err
);
    localparam logic [ADDR_W-1:0] BASE  = (ADDR_W)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

    typedef enum logic {IDLE, WRITE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              restartPend_q, restartPend_d;

    logic [31:0]       encWord;
    logic              encLegal;
    logic              inReady;
    logic              transfer;

    always_comb begin
        encWord  = '0;
        encLegal = 1'b1;
        case (bus.in_op)
            4'h2: encWord = {bus.in_op, bus.in_rd, bus.in_rs, 4'h0, 16'h0000};
            4'h3: encWord = {bus.in_op, 4'h0, bus.in_rs, 20'h00000};
            4'h6, 4'h7: begin
                encWord  = {bus.in_op, bus.in_rd, bus.in_rs, 4'h0, 11'h000, bus.in_imm[4:0]};
                encLegal = (bus.in_imm[27:5] == '0);
            end
            // Low 20 bits equal the sign-extended 16-bit immediate once the range check holds
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                encWord  = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_imm[19:0]};
                encLegal = (bus.in_imm[27:16] == {12{bus.in_imm[15]}});
            end
            4'hE, 4'hF: encWord = {bus.in_op, bus.in_imm};
            default:    encWord = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_rt, 16'h0000};
        endcase
    end

    // A pending restart blocks new work until it has been applied
    assign inReady  = rst_n && (state_q == IDLE) && !full && !start && !restartPend_q;
    assign transfer = bus.in_valid && inReady;

    always_comb begin
        state_d       = state_q;
        memAddr_d     = memAddr_q;
        memWdata_d    = memWdata_q;
        count_d       = count_q;
        err_d         = err_q;
        restartPend_d = restartPend_q;
        case (state_q)
            IDLE: begin
                if (start || restartPend_q) begin
                    memAddr_d     = BASE;
                    count_d       = '0;
                    err_d         = 1'b0;
                    restartPend_d = 1'b0;
                end else if (transfer) begin
                    if (encLegal) begin
                        memWdata_d = encWord;
                        state_d    = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (start) begin
                    restartPend_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    memAddr_d = memAddr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            memAddr_q     <= BASE;
            memWdata_q    <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
            restartPend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            memAddr_q     <= memAddr_d;
            memWdata_q    <= memWdata_d;
            count_q       <= count_d;
            err_q         <= err_d;
            restartPend_q <= restartPend_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign count         = count_q;
    assign full          = (count_q == DEPTH);
    assign err           = err_q;
endmodule
